// File: rtl/uart_rx_if.sv
// Receive-side result bus of uart_rx: the received byte, its one-cycle
// valid strobe and the per-frame error flags.
interface uart_rx_if;
  logic [7:0] DOUT;
  logic       DOUT_VLD;
  logic       FRAME_ERROR;
  logic       PARITY_ERROR;

  modport master (
    output DOUT,
    output DOUT_VLD,
    output FRAME_ERROR,
    output PARITY_ERROR
  );

  modport slave (
    input DOUT,
    input DOUT_VLD,
    input FRAME_ERROR,
    input PARITY_ERROR
  );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: 8 data bits LSB-first, optional parity bit,
// one stop bit; results are published on a uart_rx_if bus.
module uart_rx #(
  parameter string PARITY_BIT = "none"
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      UART_CLK_EN,
  input  logic      UART_RXD,
  uart_rx_if.master rx_if
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    STARTBIT  = 3'd1,
    DATABITS  = 3'd2,
    PARITYBIT = 3'd3,
    STOPBIT   = 3'd4
  } state_t;

  localparam bit HAS_PARITY = (PARITY_BIT != "none");

  function automatic logic parity_expected(input logic [7:0] data);
    logic p;
    if (PARITY_BIT == "even") begin
      p = ^data;
    end else if (PARITY_BIT == "odd") begin
      p = ~^data;
    end else if (PARITY_BIT == "mark") begin
      p = 1'b1;
    end else begin
      p = 1'b0;
    end
    return p;
  endfunction

  state_t     state_q;
  logic [3:0] os_cnt_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       par_mis_q;
  logic [7:0] dout_q;
  logic       vld_q;
  logic       ferr_q;
  logic       perr_q;

  logic       rxd_meta_q;
  logic       rxd_sync_q;
  logic       rxd_prev_q;

  logic       fall_d;
  logic       sample_d;
  logic       boundary_d;
  logic [3:0] os_cnt_d;

  assign fall_d     = rxd_prev_q & ~rxd_sync_q;
  assign sample_d   = UART_CLK_EN && (os_cnt_q == 4'd7);
  assign boundary_d = UART_CLK_EN && (os_cnt_q == 4'd15);
  assign os_cnt_d   = os_cnt_q + 4'd1;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= UART_RXD;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  // Frame FSM with oversample/bit counters and registered result outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      os_cnt_q  <= 4'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      par_mis_q <= 1'b0;
      dout_q    <= 8'h00;
      vld_q     <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      vld_q  <= 1'b0;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fall_d) begin
            state_q   <= STARTBIT;
            os_cnt_q  <= 4'd0;
            bit_cnt_q <= 3'd0;
            par_mis_q <= 1'b0;
          end
        end
        STARTBIT: begin
          if (UART_CLK_EN) begin
            os_cnt_q <= os_cnt_d;
          end
          // A start bit that is high again at mid-bit was only a glitch.
          if (sample_d && rxd_sync_q) begin
            state_q <= IDLE;
          end else if (boundary_d) begin
            state_q <= DATABITS;
          end
        end
        DATABITS: begin
          if (UART_CLK_EN) begin
            os_cnt_q <= os_cnt_d;
          end
          if (sample_d) begin
            shift_q <= {rxd_sync_q, shift_q[7:1]};
          end
          if (boundary_d) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= HAS_PARITY ? PARITYBIT : STOPBIT;
            end
          end
        end
        PARITYBIT: begin
          if (UART_CLK_EN) begin
            os_cnt_q <= os_cnt_d;
          end
          if (sample_d) begin
            par_mis_q <= (rxd_sync_q != parity_expected(shift_q));
          end
          if (boundary_d) begin
            state_q <= STOPBIT;
          end
        end
        STOPBIT: begin
          if (UART_CLK_EN) begin
            os_cnt_q <= os_cnt_d;
          end
          // Leaving at mid stop bit leaves time to catch a back-to-back start.
          if (sample_d) begin
            dout_q  <= shift_q;
            ferr_q  <= ~rxd_sync_q;
            perr_q  <= HAS_PARITY ? par_mis_q : 1'b0;
            vld_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rx_if.DOUT         = dout_q;
  assign rx_if.DOUT_VLD     = vld_q;
  assign rx_if.FRAME_ERROR  = ferr_q;
  assign rx_if.PARITY_ERROR = perr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: four receivers (none/even/odd/mark parity)
// on separate lines, directed scenarios plus randomized frames.
module tb_uart_rx;

  logic CLK = 1'b0;
  logic RST;
  logic en;
  logic rxd [4];

  int vectors     = 0;
  int miscompares = 0;

  uart_rx_if bus0 ();
  uart_rx_if bus1 ();
  uart_rx_if bus2 ();
  uart_rx_if bus3 ();

  uart_rx #(.PARITY_BIT("none")) u_none (.CLK(CLK), .RST(RST), .UART_CLK_EN(en), .UART_RXD(rxd[0]), .rx_if(bus0.master));
  uart_rx #(.PARITY_BIT("even")) u_even (.CLK(CLK), .RST(RST), .UART_CLK_EN(en), .UART_RXD(rxd[1]), .rx_if(bus1.master));
  uart_rx #(.PARITY_BIT("odd"))  u_odd  (.CLK(CLK), .RST(RST), .UART_CLK_EN(en), .UART_RXD(rxd[2]), .rx_if(bus2.master));
  uart_rx #(.PARITY_BIT("mark")) u_mark (.CLK(CLK), .RST(RST), .UART_CLK_EN(en), .UART_RXD(rxd[3]), .rx_if(bus3.master));

  always #5 CLK = ~CLK;

  logic [3:0] vld_s, fe_s, pe_s;
  logic [7:0] dout_s [4];
  assign vld_s = {bus3.DOUT_VLD, bus2.DOUT_VLD, bus1.DOUT_VLD, bus0.DOUT_VLD};
  assign fe_s  = {bus3.FRAME_ERROR, bus2.FRAME_ERROR, bus1.FRAME_ERROR, bus0.FRAME_ERROR};
  assign pe_s  = {bus3.PARITY_ERROR, bus2.PARITY_ERROR, bus1.PARITY_ERROR, bus0.PARITY_ERROR};
  assign dout_s[0] = bus0.DOUT;
  assign dout_s[1] = bus1.DOUT;
  assign dout_s[2] = bus2.DOUT;
  assign dout_s[3] = bus3.DOUT;

  // Pulse recorder: counts strobes, keeps the last frame, flags stray error bits.
  int         pulses [4] = '{0, 0, 0, 0};
  int         stray  [4] = '{0, 0, 0, 0};
  logic [7:0] rec_d  [4];
  logic       rec_fe [4];
  logic       rec_pe [4];
  always @(negedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (vld_s[i]) begin
        pulses[i] <= pulses[i] + 1;
        rec_d[i]  <= dout_s[i];
        rec_fe[i] <= fe_s[i];
        rec_pe[i] <= pe_s[i];
      end else if (fe_s[i] || pe_s[i]) begin
        stray[i] <= stray[i] + 1;
      end
    end
  end

  // Oversample enable: one CLK cycle high out of every four.
  initial begin
    en = 1'b0;
    forever begin
      repeat (3) @(negedge CLK);
      en = 1'b1;
      @(negedge CLK);
      en = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference parity bit a transmitter would send: mode 0 none, 1 even, 2 odd, 3 mark.
  function automatic logic ref_parity(input int mode, input logic [7:0] d);
    int ones;
    ones = $countones(d);
    case (mode)
      1:       return (ones % 2) == 1;
      2:       return (ones % 2) == 0;
      3:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One bit time = 16 enables = 64 CLK cycles.
  task automatic bit_t(input int line, input logic v);
    rxd[line] = v;
    repeat (64) @(negedge CLK);
  endtask

  task automatic send_frame(input int line, input logic [7:0] d, input logic par_ok, input logic stop_bit);
    bit_t(line, 1'b0);
    for (int i = 0; i < 8; i++) bit_t(line, d[i]);
    if (line != 0) bit_t(line, par_ok ? ref_parity(line, d) : ~ref_parity(line, d));
    bit_t(line, stop_bit);
  endtask

  task automatic run_frame(input int line, input logic [7:0] d, input logic par_ok, input logic stop_ok);
    int p0;
    p0 = pulses[line];
    send_frame(line, d, par_ok, stop_ok);
    if (!stop_ok) bit_t(line, 1'b1);
    chk($sformatf("pulses[%0d]", line), pulses[line] - p0, 1);
    chk($sformatf("data[%0d]", line), rec_d[line], d);
    chk($sformatf("ferr[%0d]", line), rec_fe[line], !stop_ok);
    chk($sformatf("perr[%0d]", line), rec_pe[line], (line != 0) && !par_ok);
    chk($sformatf("dout_hold[%0d]", line), dout_s[line], d);
  endtask

  initial begin
    int p0;
    RST = 1'b1;
    for (int i = 0; i < 4; i++) rxd[i] = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      chk("rst_dout", dout_s[i], 8'h00);
      chk("rst_flags", {vld_s[i], fe_s[i], pe_s[i]}, 3'b000);
    end

    run_frame(0, 8'h55, 1'b1, 1'b1);
    run_frame(1, 8'hA3, 1'b1, 1'b1);
    run_frame(1, 8'hA3, 1'b0, 1'b1);

    // Stop bit low, then line stuck low for 40 bit times.
    p0 = pulses[0];
    send_frame(0, 8'h3C, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) bit_t(0, 1'b0);
    chk("stuck_pulses", pulses[0] - p0, 1);
    chk("stuck_ferr", rec_fe[0], 1'b1);
    chk("stuck_data", rec_d[0], 8'h3C);
    bit_t(0, 1'b1);
    run_frame(0, 8'hC6, 1'b1, 1'b1);

    // Low glitch of 4 oversample ticks.
    p0 = pulses[0];
    rxd[0] = 1'b0;
    repeat (16) @(negedge CLK);
    rxd[0] = 1'b1;
    repeat (128) @(negedge CLK);
    chk("glitch_pulses", pulses[0] - p0, 0);
    run_frame(0, 8'h81, 1'b1, 1'b1);

    // Reset in the middle of data bit 4 of 0x5A; the line then stays high.
    p0 = pulses[0];
    bit_t(0, 1'b0);
    for (int i = 0; i < 4; i++) bit_t(0, ((i % 2) == 1));
    rxd[0] = 1'b1;
    repeat (32) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      chk("midrst_dout", dout_s[i], 8'h00);
      chk("midrst_flags", {vld_s[i], fe_s[i], pe_s[i]}, 3'b000);
    end
    RST = 1'b0;
    repeat (64 * 12) @(negedge CLK);
    chk("midrst_pulses", pulses[0] - p0, 0);
    run_frame(0, 8'h0F, 1'b1, 1'b1);

    // Back-to-back odd-parity frames, no idle gap.
    p0 = pulses[2];
    send_frame(2, 8'h00, 1'b1, 1'b1);
    chk("b2b_pulses1", pulses[2] - p0, 1);
    chk("b2b_data1", rec_d[2], 8'h00);
    chk("b2b_err1", {rec_fe[2], rec_pe[2]}, 2'b00);
    send_frame(2, 8'hFF, 1'b1, 1'b1);
    chk("b2b_pulses2", pulses[2] - p0, 2);
    chk("b2b_data2", rec_d[2], 8'hFF);
    chk("b2b_err2", {rec_fe[2], rec_pe[2]}, 2'b00);

    // Randomized frames on every receiver.
    for (int k = 0; k < 6; k++) begin
      for (int line = 0; line < 4; line++) begin
        run_frame(line, 8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0);
      end
    end

    for (int i = 0; i < 4; i++) chk("stray_flags", stray[i], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter PARITY_BIT, default "none", parity mode: "none", "even", "odd", "mark" or "space".
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 UART_CLK_EN  input  1  16x-oversampling enable, one CLK cycle wide; 16 enables = 1 bit time.
REQ-005 UART_RXD  input  1  asynchronous serial receive line, idle high.
REQ-006 DOUT  output  8  last received data byte.
REQ-007 DOUT_VLD  output  1  one-cycle pulse, frame complete.
REQ-008 FRAME_ERROR  output  1  stop-bit error flag, valid with DOUT_VLD.
REQ-009 PARITY_ERROR  output  1  parity mismatch flag, valid with DOUT_VLD.

Function
REQ-010 UART_RXD SHALL pass a 2-FF synchronizer, reset to 1, plus one registered copy for edge detection; all FSM decisions use the synchronized value.
REQ-011 FSM states SHALL be IDLE, STARTBIT, DATABITS, PARITYBIT, STOPBIT.
REQ-012 Oversample counter SHALL be 4-bit, clear on start detection, increment on each UART_CLK_EN outside IDLE, and wrap 15->0.
REQ-013 Sample point SHALL be counter==7 with UART_CLK_EN high; bit boundary SHALL be counter==15 with UART_CLK_EN high.
REQ-014 IDLE -> STARTBIT SHALL occur only on a synchronized falling edge (previous 1, current 0); a line held low SHALL NOT start a frame.
REQ-015 STARTBIT: sample==1 SHALL return to IDLE (glitch reject, no output); sample==0 SHALL continue; boundary -> DATABITS.
REQ-016 DATABITS: each sample SHALL shift into an 8-bit register LSB-first (right shift, new bit at MSB).
REQ-017 A 3-bit bit counter SHALL count 0..7; the boundary with count==7 SHALL go to PARITYBIT, or STOPBIT when PARITY_BIT=="none".
REQ-018 PARITYBIT: the sample SHALL be compared to expected parity (even: ^data; odd: ~^data; mark: 1; space: 0); boundary -> STOPBIT.
REQ-019 STOPBIT: at the sample point, DOUT SHALL load the shift register, FRAME_ERROR SHALL = ~sample, PARITY_ERROR SHALL = mismatch (0 for "none"), DOUT_VLD SHALL pulse, and the FSM SHALL go to IDLE in the same cycle.
REQ-020 Latency: DOUT_VLD SHALL be high exactly one CLK after the UART_CLK_EN cycle sampling the stop bit.
REQ-021 DOUT SHALL hold until the next completed frame; error flags SHALL be 0 whenever DOUT_VLD is 0.
REQ-022 Every frame reaching STOPBIT SHALL produce DOUT_VLD, including errored frames.
REQ-023 Back-to-back frames (next start bit directly after the stop bit) SHALL be received without loss, because of the early return to IDLE.
REQ-024 Without UART_CLK_EN, the FSM and counters SHALL hold state; edge detection continues.

Reset
REQ-025 On RST: state=IDLE; counters=0; shift register=0; DOUT=0x00; DOUT_VLD=0; FRAME_ERROR=0; PARITY_ERROR=0; synchronizer and edge registers=1.
REQ-026 RST SHALL override all activity in any state, including mid-frame, with no DOUT_VLD for the aborted frame.

Verification
REQ-027 "none" parity, frame 0x55, valid stop bit -> one DOUT_VLD pulse, DOUT=0x55, FRAME_ERROR=0, PARITY_ERROR=0.
REQ-028 "even" parity, 0xA3 with parity bit 0 -> DOUT=0xA3, PARITY_ERROR=0; same byte with parity bit 1 -> DOUT=0xA3, PARITY_ERROR=1.
REQ-029 Frame 0x3C with stop bit 0, line then held low for 40 bit times -> one pulse with FRAME_ERROR=1, DOUT=0x3C, no further pulses until the line returns high and falls again.
REQ-030 Low glitch of 4 oversample ticks -> no DOUT_VLD; FSM back in IDLE; next frame 0x81 received correctly.
REQ-031 RST during DATABITS bit 4 -> all outputs 0 next cycle, no pulse; following frame 0x0F -> DOUT=0x0F.
REQ-032 Back-to-back frames 0x00 then 0xFF, no idle gap, "odd" parity -> two pulses, DOUT 0x00 then 0xFF, no errors.
